// File: rtl/sprite_pkg.sv
// Shared types and widths for the sprite ROM arbiter.
package sprite_pkg;

    localparam int SPRITE_ADDR_W = 12;
    localparam int SPRITE_DATA_W = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        PAUSED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester, pause and ROM-side bundle of the sprite ROM arbiter.
interface sprite_rom_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    // Handshake: a requester holds req[i] with a stable address until grant[i];
    // grant is combinational and the address is consumed in that same cycle.
    // rd_valid is a one-cycle strobe with no back-pressure.
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        grant;
    logic                      pause;
    logic                      idle;
    logic [ADDR_W-1:0]         rom_address;
    logic [DATA_W-1:0]         rom_q;
    logic                      rd_valid;
    logic [ID_W-1:0]           rd_id;
    logic [DATA_W-1:0]         rd_data;

    modport master (
        output req, addr, pause, rom_q,
        input  grant, idle, rom_address, rd_valid, rd_id, rd_data
    );

    modport slave (
        input  req, addr, pause, rom_q,
        output grant, idle, rom_address, rd_valid, rd_id, rd_data
    );

endinterface

// File: rtl/sprite_rom_arbiter_rr_select.sv
// Round-robin selector: first active request at or after ptr, wrapping.
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    index
);
    logic            found;
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] j;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        sum   = '0;
        j     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
            j = sum[ID_W-1:0];
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = j;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM between NUM_REQ fetchers.
// Optional perf counters are built when SPRITE_ROM_ARB_PERF_EN is defined.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = SPRITE_ADDR_W,
    parameter int DATA_W  = SPRITE_DATA_W,
    parameter int ROM_LAT = 1
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    sprite_rom_arbiter_if.slave  bus,
    output arb_state_t           state
`ifdef SPRITE_ROM_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0] perf_grant_cnt,
    output logic [15:0]           perf_stall_cnt
`endif
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    sel_idx;
    logic [NUM_REQ-1:0] sel_grant;
    logic               grant_en;
    logic               grant_any;
    logic [ADDR_W-1:0]  addr_sel;
    logic               drain_done;
    logic               idle_r;
    logic [ADDR_W-1:0]  rom_address_r;
    logic [ROM_LAT:0]   pipe_v;
    logic [ID_W-1:0]    pipe_id [ROM_LAT+1];

    rr_select #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_select (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (sel_grant),
        .index (sel_idx)
    );

    assign grant_en  = (state == RUN) && !bus.pause;
    assign bus.grant = grant_en ? sel_grant : '0;
    assign grant_any = grant_en && (|sel_grant);

    always_comb begin
        addr_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_grant[k]) addr_sel = bus.addr[ADDR_W*k +: ADDR_W];
        end
    end

    // The last stage retires this edge, so draining is done once the earlier stages are empty.
    assign drain_done = ~|pipe_v[ROM_LAT-1:0];

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RUN;
            idle_r        <= 1'b0;
            ptr           <= '0;
            rom_address_r <= '0;
            pipe_v        <= '0;
            for (int s = 0; s <= ROM_LAT; s++) pipe_id[s] <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.pause) state <= DRAIN;
                end
                DRAIN: begin
                    if (!bus.pause) begin
                        state <= RUN;
                    end else if (drain_done) begin
                        state  <= PAUSED;
                        idle_r <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (!bus.pause) begin
                        state  <= RUN;
                        idle_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    idle_r <= 1'b0;
                end
            endcase
            if (grant_any) begin
                ptr           <= (sel_idx == ID_W'(NUM_REQ-1)) ? '0 : sel_idx + 1'b1;
                rom_address_r <= addr_sel;
            end
            pipe_v     <= {pipe_v[ROM_LAT-1:0], grant_any};
            pipe_id[0] <= sel_idx;
            for (int s = 1; s <= ROM_LAT; s++) pipe_id[s] <= pipe_id[s-1];
        end
    end

    assign bus.idle        = idle_r;
    assign bus.rom_address = rom_address_r;
    assign bus.rd_valid    = pipe_v[ROM_LAT];
    assign bus.rd_id       = pipe_id[ROM_LAT];
    assign bus.rd_data     = pipe_v[ROM_LAT] ? bus.rom_q : '0;

`ifdef SPRITE_ROM_ARB_PERF_EN
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (bus.grant[k] && perf_grant_cnt[16*k +: 16] != 16'hFFFF)
                    perf_grant_cnt[16*k +: 16] <= perf_grant_cnt[16*k +: 16] + 16'd1;
            end
            if ((|bus.req) && !bus.pause && !grant_any && perf_stall_cnt != 16'hFFFF)
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a one-cycle model ROM.
module tb_sprite_rom_arbiter;
    import sprite_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 4;
    localparam int ROM_LAT = 1;

    // clock / reset
    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 vga_clk = ~vga_clk;

    sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    arb_state_t state;
`ifdef SPRITE_ROM_ARB_PERF_EN
    logic [NUM_REQ*16-1:0] perf_grant_cnt;
    logic [15:0]           perf_stall_cnt;
`endif

    sprite_rom_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus),
        .state   (state)
`ifdef SPRITE_ROM_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // model ROM: data = xor of the three address nibbles, one cycle latency
    function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8];
    endfunction

    always @(posedge vga_clk) bus.rom_q <= rom_fn(bus.rom_address);

    // hand-computed ROM contents at each requester's address
    logic [DATA_W-1:0] exp_data [NUM_REQ];
    initial begin
        exp_data[0] = 4'h1;  // 0x010
        exp_data[1] = 4'hF;  // 0x0A5
        exp_data[2] = 4'h2;  // 0x200
        exp_data[3] = 4'h6;  // 0x071
    end

    // scoreboard counters
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic next_cycle();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge vga_clk);
    endtask

    task automatic chk_rd(input string tag, input int id);
        check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        check({tag, "_id"},    32'(bus.rd_id),    32'(id));
        check({tag, "_data"},  32'(bus.rd_data),  32'(exp_data[id]));
    endtask

    initial begin
        bus.req   = '0;
        bus.pause = 1'b0;
        bus.addr  = {12'h071, 12'h200, 12'h0A5, 12'h010};
        reset_n   = 1'b0;
        repeat (2) @(posedge vga_clk);
        sample();
        check("rst_rd_valid", 32'(bus.rd_valid),    32'd0);
        check("rst_rd_id",    32'(bus.rd_id),       32'd0);
        check("rst_rd_data",  32'(bus.rd_data),     32'd0);
        check("rst_rom_addr", 32'(bus.rom_address), 32'd0);
        check("rst_idle",     32'(bus.idle),        32'd0);
        check("rst_state",    32'(state),           32'(RUN));
        check("rst_grant",    32'(bus.grant),       32'd0);

        // two requesters alternate; first grant right after release
        next_cycle(); reset_n = 1'b1; bus.req = 4'b0101;
        sample(); check("alt_g0", 32'(bus.grant), 32'b0001); check("alt_rv0", 32'(bus.rd_valid), 32'd0);
        next_cycle(); sample();
        check("alt_g1", 32'(bus.grant), 32'b0100); check("alt_ra1", 32'(bus.rom_address), 32'h010);
        check("alt_rv1", 32'(bus.rd_valid), 32'd0);
        next_cycle(); sample();
        check("alt_g2", 32'(bus.grant), 32'b0001); check("alt_ra2", 32'(bus.rom_address), 32'h200);
        chk_rd("alt_rd2", 0);
        next_cycle(); sample();
        check("alt_g3", 32'(bus.grant), 32'b0100); chk_rd("alt_rd3", 2);
        next_cycle(); bus.req = '0; sample();
        check("alt_g4", 32'(bus.grant), 32'd0); chk_rd("alt_rd4", 0);
        next_cycle(); sample(); chk_rd("alt_rd5", 2);
        next_cycle(); sample();
        check("alt_rv6", 32'(bus.rd_valid), 32'd0);
        check("alt_hold_addr", 32'(bus.rom_address), 32'h200);

        // stream from ptr=3, then asynchronous reset mid-stream
        next_cycle(); bus.req = 4'b1111; sample(); check("ms_g0", 32'(bus.grant), 32'b1000);
        next_cycle(); sample(); check("ms_g1", 32'(bus.grant), 32'b0001);
        next_cycle(); sample(); check("ms_g2", 32'(bus.grant), 32'b0010); chk_rd("ms_rd2", 3);
        next_cycle();
        check("ms_pre_rv", 32'(bus.rd_valid), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("ms_async_rv",   32'(bus.rd_valid),    32'd0);
        check("ms_async_addr", 32'(bus.rom_address), 32'd0);
        check("ms_async_st",   32'(state),           32'(RUN));

        // full round-robin after release
        next_cycle(); reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample();
            check($sformatf("rr_g%0d", i), 32'(bus.grant), 32'(1 << (i % 4)));
            if (i >= 2) chk_rd($sformatf("rr_rd%0d", i), (i - 2) % 4);
            next_cycle();
        end
        bus.req = '0;
        sample(); check("rr_g8", 32'(bus.grant), 32'd0); chk_rd("rr_rd8", 2);
        next_cycle(); sample(); chk_rd("rr_rd9", 3);
        next_cycle(); sample(); check("rr_rv10", 32'(bus.rd_valid), 32'd0);

        // pause with two reads in flight
        next_cycle(); bus.req = 4'b1111; sample(); check("pz_g0", 32'(bus.grant), 32'b0001);
        next_cycle(); sample(); check("pz_g1", 32'(bus.grant), 32'b0010);
        next_cycle(); bus.pause = 1'b1; sample();
        check("pz_g2", 32'(bus.grant), 32'd0); chk_rd("pz_rd2", 0);
        check("pz_idle2", 32'(bus.idle), 32'd0);
        next_cycle(); sample();
        check("pz_g3", 32'(bus.grant), 32'd0); chk_rd("pz_rd3", 1);
        check("pz_idle3", 32'(bus.idle), 32'd0); check("pz_st3", 32'(state), 32'(DRAIN));
        next_cycle(); sample();
        check("pz_rv4", 32'(bus.rd_valid), 32'd0); check("pz_idle4", 32'(bus.idle), 32'd1);
        check("pz_st4", 32'(state), 32'(PAUSED)); check("pz_g4", 32'(bus.grant), 32'd0);
        next_cycle(); bus.pause = 1'b0; sample();
        check("pz_g5", 32'(bus.grant), 32'd0); check("pz_idle5", 32'(bus.idle), 32'd1);
        next_cycle(); sample();
        check("pz_st6", 32'(state), 32'(RUN)); check("pz_idle6", 32'(bus.idle), 32'd0);
        check("pz_g6", 32'(bus.grant), 32'b0100);

        // pause released during DRAIN
        next_cycle(); sample(); check("dr_g0", 32'(bus.grant), 32'b1000);
        next_cycle(); bus.pause = 1'b1; sample(); check("dr_g1", 32'(bus.grant), 32'd0);
        next_cycle(); bus.pause = 1'b0; sample();
        check("dr_st2", 32'(state), 32'(DRAIN)); check("dr_g2", 32'(bus.grant), 32'd0);
        chk_rd("dr_rd2", 3);
        next_cycle(); sample();
        check("dr_st3", 32'(state), 32'(RUN)); check("dr_g3", 32'(bus.grant), 32'b0001);

        // requester 3 withdraws without being granted
        next_cycle(); bus.req = 4'b1010; sample(); check("wd_g0", 32'(bus.grant), 32'b0010);
        next_cycle(); bus.req = 4'b0000; sample();
        check("wd_g1", 32'(bus.grant), 32'd0); chk_rd("wd_rd1", 0);
        next_cycle(); sample(); check("wd_g2", 32'(bus.grant), 32'd0); chk_rd("wd_rd2", 1);

        // single requester held is granted every cycle
        next_cycle(); bus.req = 4'b0100; sample();
        check("one_rv0", 32'(bus.rd_valid), 32'd0); check("one_g0", 32'(bus.grant), 32'b0100);
        next_cycle(); sample(); check("one_g1", 32'(bus.grant), 32'b0100);
        next_cycle(); sample(); check("one_g2", 32'(bus.grant), 32'b0100); chk_rd("one_rd2", 2);
        next_cycle(); bus.req = '0;

`ifdef SPRITE_ROM_ARB_PERF_EN
        reset_n = 1'b0;
        next_cycle(); reset_n = 1'b1; bus.req = 4'b0001;
        repeat (70000) @(posedge vga_clk);
        sample();
        check("perf_g0", 32'(perf_grant_cnt[15:0]),  32'hFFFF);
        check("perf_g1", 32'(perf_grant_cnt[31:16]), 32'd0);
        check("perf_g2", 32'(perf_grant_cnt[47:32]), 32'd0);
        check("perf_g3", 32'(perf_grant_cnt[63:48]), 32'd0);
        check("perf_stall", 32'(perf_stall_cnt), 32'd0);
        next_cycle(); bus.req = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
